// File: rtl/ras.sv
// rtl/ras.sv - return address stack with checkpoint restore (optional top repair: RAS_REPAIR_EN)
module ras #(
  parameter int RAS_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          push_valid,
  input  logic [31:0]                   push_addr,
  input  logic                          pop_valid,
  input  logic                          restore_valid,
  input  logic [$clog2(RAS_DEPTH)-1:0]  restore_ptr,
  input  logic [$clog2(RAS_DEPTH):0]    restore_cnt,
  input  logic [31:0]                   restore_top,
  output logic                          top_valid,
  output logic [31:0]                   top_addr,
  output logic [$clog2(RAS_DEPTH)-1:0]  ckpt_ptr,
  output logic [$clog2(RAS_DEPTH):0]    ckpt_cnt,
  output logic                          underflow
);

  localparam int PTRW = $clog2(RAS_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(RAS_DEPTH);
  localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [31:0]     entry [RAS_DEPTH];
  logic [PTRW-1:0] ptr_q, ptr_d, ptr_m1;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            underflow_q, underflow_d;
  logic            empty, full;
  logic            wr_en;
  logic [PTRW-1:0] wr_idx;
  logic [31:0]     wr_data;

  // Pointer arithmetic wraps naturally because the depth is a power of two
  assign ptr_m1 = ptr_q - PTR_ONE;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == DEPTH_C);

  assign top_valid = !empty;
  assign top_addr  = empty ? 32'h0 : entry[ptr_m1];
  assign ckpt_ptr  = ptr_q;
  assign ckpt_cnt  = cnt_q;
  assign underflow = underflow_q;

`ifndef RAS_REPAIR_EN
  // The checkpointed top value only matters when repair is built in
  logic unused_restore_top;
  assign unused_restore_top = ^restore_top;
`endif

  // Next pointer/occupancy and the single entry write; restore beats push/pop
  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = ptr_q;
    wr_data     = push_addr;
    if (restore_valid) begin
      ptr_d = restore_ptr;
      cnt_d = (restore_cnt > DEPTH_C) ? DEPTH_C : restore_cnt;
`ifdef RAS_REPAIR_EN
      if (restore_cnt != '0) begin
        wr_en   = 1'b1;
        wr_idx  = restore_ptr - PTR_ONE;
        wr_data = restore_top;
      end
`endif
    end else if (push_valid && pop_valid && !empty) begin
      // Return then call: replace the top in place
      wr_en  = 1'b1;
      wr_idx = ptr_m1;
    end else if (push_valid) begin
      // Full stack wraps and silently overwrites the oldest entry
      wr_en = 1'b1;
      ptr_d = ptr_q + PTR_ONE;
      cnt_d = full ? cnt_q : cnt_q + CNT_ONE;
    end else if (pop_valid) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        ptr_d = ptr_m1;
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // Pointer, occupancy and underflow pulse registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage is not reset; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (resetn && wr_en) begin
      entry[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_ras.sv
// tb/tb_ras.sv - directed self-checking bench for ras
module tb_ras;

  logic        clk;
  logic        resetn;
  logic        push_valid;
  logic [31:0] push_addr;
  logic        pop_valid;
  logic        restore_valid;
  logic [2:0]  restore_ptr;
  logic [3:0]  restore_cnt;
  logic [31:0] restore_top;
  logic        top_valid;
  logic [31:0] top_addr;
  logic [2:0]  ckpt_ptr;
  logic [3:0]  ckpt_cnt;
  logic        underflow;

  int n_checks;
  int n_fail;

  ras #(.RAS_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .push_valid(push_valid), .push_addr(push_addr), .pop_valid(pop_valid),
    .restore_valid(restore_valid), .restore_ptr(restore_ptr),
    .restore_cnt(restore_cnt), .restore_top(restore_top),
    .top_valid(top_valid), .top_addr(top_addr),
    .ckpt_ptr(ckpt_ptr), .ckpt_cnt(ckpt_cnt), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid    = 1'b0;
    push_addr     = 32'h0;
    pop_valid     = 1'b0;
    restore_valid = 1'b0;
    restore_ptr   = '0;
    restore_cnt   = '0;
    restore_top   = 32'h0;
  endtask

  task automatic do_push(input logic [31:0] a);
    push_valid = 1'b1; push_addr = a;
    tick();
    idle();
  endtask

  task automatic do_pop();
    pop_valid = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    tick();
    tick();
    n_checks++; if (top_valid !== 1'b0) begin n_fail++; $display("FAIL reset_top_valid got %0b want 0", top_valid); end
    n_checks++; if (top_addr !== 32'h0) begin n_fail++; $display("FAIL reset_top_addr got %h want 0", top_addr); end
    n_checks++; if (ckpt_ptr !== 3'd0) begin n_fail++; $display("FAIL reset_ptr got %0d want 0", ckpt_ptr); end
    n_checks++; if (ckpt_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", ckpt_cnt); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got %0b want 0", underflow); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_push_pop();
    do_reset();
    do_push(32'h1000);
    do_push(32'h2000);
    n_checks++; if (top_addr !== 32'h2000) begin n_fail++; $display("FAIL pp_top2 got %h want 2000", top_addr); end
    n_checks++; if (ckpt_cnt !== 4'd2) begin n_fail++; $display("FAIL pp_cnt2 got %0d want 2", ckpt_cnt); end
    n_checks++; if (top_valid !== 1'b1) begin n_fail++; $display("FAIL pp_valid got %0b want 1", top_valid); end
    do_pop();
    n_checks++; if (top_addr !== 32'h1000) begin n_fail++; $display("FAIL pp_top1 got %h want 1000", top_addr); end
    n_checks++; if (ckpt_cnt !== 4'd1) begin n_fail++; $display("FAIL pp_cnt1 got %0d want 1", ckpt_cnt); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_top;
    do_reset();
    for (int i = 1; i <= 9; i++) do_push(32'h100 * i);
    n_checks++; if (ckpt_cnt !== 4'd8) begin n_fail++; $display("FAIL wrap_cnt got %0d want 8", ckpt_cnt); end
    n_checks++; if (ckpt_ptr !== 3'd1) begin n_fail++; $display("FAIL wrap_ptr got %0d want 1", ckpt_ptr); end
    n_checks++; if (top_addr !== 32'h900) begin n_fail++; $display("FAIL wrap_top got %h want 900", top_addr); end
    for (int i = 0; i < 8; i++) begin
      do_pop();
      exp_top = (i < 7) ? (32'h800 - 32'h100 * i) : 32'h0;
      n_checks++; if (ckpt_cnt !== 4'(7 - i)) begin n_fail++; $display("FAIL wrap_pop_cnt[%0d] got %0d want %0d", i, ckpt_cnt, 7 - i); end
      n_checks++; if (top_addr !== exp_top) begin n_fail++; $display("FAIL wrap_pop_top[%0d] got %h want %h", i, top_addr, exp_top); end
    end
    n_checks++; if (top_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got %0b want 0", top_valid); end
  endtask

  task automatic test_underflow();
    do_reset();
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_pre got %0b want 0", underflow); end
    do_pop();
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_pulse got %0b want 1", underflow); end
    n_checks++; if (ckpt_ptr !== 3'd0 || ckpt_cnt !== 4'd0) begin n_fail++; $display("FAIL uf_state got ptr %0d cnt %0d want 0 0", ckpt_ptr, ckpt_cnt); end
    n_checks++; if (top_addr !== 32'h0) begin n_fail++; $display("FAIL uf_top got %h want 0", top_addr); end
    tick();
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_one_cycle got %0b want 0", underflow); end
    // push and pop together while empty acts as a plain push
    push_valid = 1'b1; push_addr = 32'hABC0; pop_valid = 1'b1;
    tick();
    idle();
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_pushpop_empty got %0b want 0", underflow); end
    n_checks++; if (ckpt_cnt !== 4'd1 || top_addr !== 32'hABC0) begin n_fail++; $display("FAIL pushpop_empty got cnt %0d top %h want 1 abc0", ckpt_cnt, top_addr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_push(32'h1000);
    do_push(32'h2000);
    push_valid = 1'b1; push_addr = 32'h3000; pop_valid = 1'b1;
    tick();
    idle();
    n_checks++; if (top_addr !== 32'h3000) begin n_fail++; $display("FAIL b2b_top got %h want 3000", top_addr); end
    n_checks++; if (ckpt_cnt !== 4'd2 || ckpt_ptr !== 3'd2) begin n_fail++; $display("FAIL b2b_state got ptr %0d cnt %0d want 2 2", ckpt_ptr, ckpt_cnt); end
    do_pop();
    n_checks++; if (top_addr !== 32'h1000) begin n_fail++; $display("FAIL b2b_below got %h want 1000", top_addr); end
  endtask

  task automatic test_restore();
    logic [31:0] exp_top;
`ifdef RAS_REPAIR_EN
    exp_top = 32'h2000;
`else
    exp_top = 32'h5000;
`endif
    do_reset();
    do_push(32'h1000);
    do_push(32'h2000);
    do_pop();
    do_push(32'h5000);
    n_checks++; if (top_addr !== 32'h5000) begin n_fail++; $display("FAIL rst_clobber got %h want 5000", top_addr); end
    restore_valid = 1'b1; restore_ptr = 3'd2; restore_cnt = 4'd2; restore_top = 32'h2000;
    tick();
    idle();
    n_checks++; if (top_addr !== exp_top) begin n_fail++; $display("FAIL rst_top got %h want %h", top_addr, exp_top); end
    n_checks++; if (ckpt_ptr !== 3'd2 || ckpt_cnt !== 4'd2) begin n_fail++; $display("FAIL rst_state got ptr %0d cnt %0d want 2 2", ckpt_ptr, ckpt_cnt); end
  endtask

  task automatic test_restore_priority();
    do_reset();
    do_push(32'h1000);
    do_push(32'h2000);
    restore_valid = 1'b1; restore_ptr = 3'd1; restore_cnt = 4'd1; restore_top = 32'h1000;
    push_valid = 1'b1; push_addr = 32'h7000; pop_valid = 1'b0;
    tick();
    idle();
    n_checks++; if (ckpt_ptr !== 3'd1 || ckpt_cnt !== 4'd1) begin n_fail++; $display("FAIL prio_state got ptr %0d cnt %0d want 1 1", ckpt_ptr, ckpt_cnt); end
    n_checks++; if (top_addr !== 32'h1000) begin n_fail++; $display("FAIL prio_top got %h want 1000", top_addr); end
    // oversized checkpoint count clamps to the depth
    restore_valid = 1'b1; restore_ptr = 3'd3; restore_cnt = 4'd12; pop_valid = 1'b1;
    tick();
    idle();
    n_checks++; if (ckpt_cnt !== 4'd8 || ckpt_ptr !== 3'd3) begin n_fail++; $display("FAIL clamp got ptr %0d cnt %0d want 3 8", ckpt_ptr, ckpt_cnt); end
  endtask

  task automatic test_reset_mid_push();
    do_reset();
    do_push(32'h1000);
    push_valid = 1'b1; push_addr = 32'h2000;
    #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (ckpt_cnt !== 4'd0 || top_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_now got cnt %0d valid %0b want 0 0", ckpt_cnt, top_valid); end
    tick();
    n_checks++; if (ckpt_cnt !== 4'd0 || ckpt_ptr !== 3'd0) begin n_fail++; $display("FAIL midrst_held got ptr %0d cnt %0d want 0 0", ckpt_ptr, ckpt_cnt); end
    idle();
    resetn = 1'b1;
    tick();
    n_checks++; if (top_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_top got %h want 0", top_addr); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    idle();
    #1;
    test_reset();
    test_push_pop();
    test_wrap();
    test_underflow();
    test_back_to_back();
    test_restore();
    test_restore_priority();
    test_reset_mid_push();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ras.md
RAS -- requirements
Module: ras

Interface
REQ-001 SHALL provide parameter RAS_DEPTH, default 8, meaning the number of return-address entries; a power of two, at least 2.
REQ-002 SHALL derive PTRW = $clog2(RAS_DEPTH) and CNTW = PTRW+1 as localparams.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 push_valid  input  1  call fetched this cycle (fetch stage derives it from BTB ins_type).
REQ-006 push_addr  input  32  return address to push (call pc + 4).
REQ-007 pop_valid  input  1  return fetched this cycle.
REQ-008 restore_valid  input  1  branch mistaken; restore the checkpoint.
REQ-009 restore_ptr  input  PTRW  checkpointed pointer.
REQ-010 restore_cnt  input  CNTW  checkpointed occupancy.
REQ-011 restore_top  input  32  checkpointed top-entry value.
REQ-012 top_valid  output  1  stack is non-empty.
REQ-013 top_addr  output  32  predicted return target.
REQ-014 ckpt_ptr  output  PTRW  current pointer, carried down the pipeline.
REQ-015 ckpt_cnt  output  CNTW  current occupancy, carried down the pipeline.
REQ-016 underflow  output  1  registered one-cycle pulse on a pop while empty.

Function
REQ-017 Storage SHALL be RAS_DEPTH x 32-bit entries, ptr (PTRW bits) indexing the next free slot, and cnt (CNTW bits) in 0..RAS_DEPTH.
REQ-018 top_addr SHALL be combinational: entry[ptr-1 mod RAS_DEPTH] when cnt != 0, else 32'b0; top_valid = (cnt != 0).
REQ-019 ckpt_ptr/ckpt_cnt SHALL equal the current registered ptr/cnt, i.e. the state before this cycle's push/pop.
REQ-020 Push only: entry[ptr] <= push_addr, ptr <= ptr+1 mod RAS_DEPTH, cnt <= min(cnt+1, RAS_DEPTH); the value is visible on top_addr the next cycle.
REQ-021 Push when full SHALL wrap and overwrite the oldest entry, with cnt held at RAS_DEPTH.
REQ-022 Pop only with cnt != 0: ptr <= ptr-1 mod RAS_DEPTH, cnt <= cnt-1; entry contents are untouched.
REQ-023 Pop only with cnt == 0: ptr and cnt unchanged; underflow = 1 the next cycle.
REQ-024 Push and pop in the same cycle with cnt != 0: entry[ptr-1] <= push_addr; ptr and cnt unchanged.
REQ-025 Push and pop in the same cycle with cnt == 0: behave as push only; no underflow.
REQ-026 restore_valid SHALL have priority over push/pop that cycle: ptr <= restore_ptr, cnt <= min(restore_cnt, RAS_DEPTH); push_valid and pop_valid are ignored.
REQ-027 underflow SHALL be 0 in every cycle not covered by REQ-023.

Reset
REQ-028 On resetn low, immediately: ptr = 0, cnt = 0, underflow = 0; thus top_valid = 0 and top_addr = 0.
REQ-029 Entry storage SHALL NOT be reset; it is unobservable while cnt = 0.
REQ-030 Reset asserted mid-operation SHALL discard any same-cycle push, pop or restore.

Configuration
REQ-031 Macro RAS_REPAIR_EN defined: a restore SHALL also write entry[restore_ptr-1 mod RAS_DEPTH] <= restore_top whenever restore_cnt != 0.
REQ-032 Macro RAS_REPAIR_EN undefined: restore changes only ptr/cnt; restore_top is ignored and entry storage is untouched.

Verification
REQ-033 Reset, then push 0x1000 and 0x2000 -> top_addr = 0x2000, cnt = 2; pop -> top_addr = 0x1000, cnt = 1.
REQ-034 Nine pushes 0x100..0x900 (step 0x100, RAS_DEPTH = 8) -> cnt = 8, ptr = 1, top = 0x900; eight pops return 0x800..0x200 then cnt = 0, and the oldest (0x100) is lost.
REQ-035 Pop while empty -> underflow high for exactly one cycle, ptr = cnt = 0, top_addr = 0.
REQ-036 With top = 0x2000, push 0x3000 and pop in the same cycle -> top = 0x3000, cnt unchanged.
REQ-037 Checkpoint (ptr 2, cnt 2, top 0x2000), then pop and push 0x5000 -> entry[1] = 0x5000; restore that checkpoint -> top_addr = 0x2000 with RAS_REPAIR_EN, 0x5000 without.
REQ-038 restore_valid together with push_valid -> the push is dropped and the state equals the checkpoint; resetn low mid-push -> cnt = 0 immediately.
